// File: rtl/time_package.sv
// Shared time type and scheduler state encoding for the emulation scheduler.
package time_package;

  localparam int TIME_W = 32;

  // Emulated time is a plain unsigned count; no wrap handling anywhere.
  typedef logic [TIME_W-1:0] TIME_FORMAT;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    COMMIT,
    HALT
  } sched_state_t;

endpackage

// File: rtl/time_min_tree.sv
// Combinational minimum finder: smallest requested time plus a mask of every
// requester whose time equals that minimum (ties are all reported).
module time_min_tree
  import time_package::*;
#(
  parameter int N = 2
) (
  input  TIME_FORMAT [N-1:0] times,
  output TIME_FORMAT         min_time,
  output logic [N-1:0]       tie_mask
);

  // Unsigned minimum, then flag every entry equal to it.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path can leave a value held and infer a latch.
    min_time = times[0];
    tie_mask = '0;
    for (int i = 1; i < N; i++) begin
      if (times[i] < min_time) min_time = times[i];
    end
    for (int i = 0; i < N; i++) begin
      tie_mask[i] = (times[i] == min_time);
    end
  end

endmodule

// File: rtl/emu_scheduler.sv
// Conservative time-advance scheduler: waits until every requester presents
// its next-event time, commits the minimum, and grants all tied requesters.
module emu_scheduler
  import time_package::*;
#(
  parameter int N         = 2,
  parameter int STEP_BITS = 32
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 run,
  input  logic [N-1:0]         req_valid,
  input  TIME_FORMAT [N-1:0]   req_time,
  input  logic                 stop_en,
  input  TIME_FORMAT           stop_time,
  output logic [N-1:0]         grant,
  output TIME_FORMAT           time_curr,
  output logic                 step_valid,
  output logic [STEP_BITS-1:0] step_count,
  output logic                 halted,
  output logic                 order_err
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("emu_scheduler: N must be in 2..8");
  end

  sched_state_t state, state_next;
  TIME_FORMAT   time_next_q;
  logic [N-1:0] grant_q;
  TIME_FORMAT   min_time;
  logic [N-1:0] tie_mask;
  logic         sample;

  time_min_tree #(.N(N)) u_min (
    .times    (req_time),
    .min_time (min_time),
    .tie_mask (tie_mask)
  );

  // A GATHER sample happens only while running with every requester valid.
  assign sample = (state == GATHER) && run && (&req_valid);

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; COMMIT always completes even if run has dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (run) state_next = GATHER;
      GATHER:  if (!run) state_next = IDLE;
               else if (&req_valid) state_next = COMMIT;
      COMMIT:  if (stop_en && (time_next_q >= stop_time)) state_next = HALT;
               else state_next = GATHER;
      HALT:    if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state, so an async reset clears them immediately.
  always_comb begin
    grant      = (state == COMMIT) ? grant_q : '0;
    step_valid = (state == COMMIT);
    halted     = (state == HALT);
  end

  // Datapath: capture the minimum in GATHER, commit it on leaving COMMIT.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      time_curr   <= '0;
      time_next_q <= '0;
      grant_q     <= '0;
      step_count  <= '0;
      order_err   <= 1'b0;
    end else begin
      if (sample) begin
        time_next_q <= min_time;
        grant_q     <= tie_mask;
      end
      if (state == COMMIT) begin
        time_curr <= time_next_q;
        if (step_count != '1) step_count <= step_count + 1'b1;
        if (time_next_q < time_curr) order_err <= 1'b1;
      end
    end
  end

endmodule
